// File: rtl/cluster_vector_driver.sv
`default_nettype none
// ============================================================================
// Module   : cluster_vector_driver
// Function : Assembles beat-streamed stimulus into the wide input vector of a
//            learned-logic cluster. After a settle time it captures the cluster
//            outputs, compares them with the expected value and returns the
//            result with saturating test/error counters.
//            Optional per-bit compare mask: define CLUSTER_DRV_MASK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cluster_vector_driver #(
    parameter int IN_W   = 1894,
    parameter int OUT_W  = 8,
    parameter int WORD_W = 32,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_last,
    input  logic [OUT_W-1:0]  s_exp,
`ifdef CLUSTER_DRV_MASK_EN
    input  logic [OUT_W-1:0]  s_mask,
`endif
    output logic [IN_W-1:0]   vec_o,
    input  logic [OUT_W-1:0]  res_i,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [OUT_W-1:0]  m_data,
    output logic              m_mismatch,
    output logic [CNT_W-1:0]  test_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              proto_err,
    input  logic              clr
);

    localparam int c_NBEATS  = (IN_W + WORD_W - 1) / WORD_W;
    localparam int c_BCNT_W  = (c_NBEATS > 1) ? $clog2(c_NBEATS) : 1;
    localparam int c_LAST_LO = (c_NBEATS - 1) * WORD_W;
    localparam int c_LAST_W  = IN_W - c_LAST_LO;
    localparam logic [c_BCNT_W-1:0] c_BCNT_MAX = c_BCNT_W'(c_NBEATS - 1);
    localparam logic [7:0]          c_SETTLE   = 8'(SETTLE);

    localparam logic [1:0] c_ST_LOAD = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    logic [1:0]          r_state;
    logic [c_BCNT_W-1:0] r_bcnt;
    logic                r_full;
    logic [IN_W-1:0]     r_vec;
    logic [OUT_W-1:0]    r_exp;
    logic [7:0]          r_settle;
    logic                r_m_valid;
    logic [OUT_W-1:0]    r_m_data;
    logic                r_m_mis;
    logic [CNT_W-1:0]    r_test_cnt;
    logic [CNT_W-1:0]    r_err_cnt;
    logic                r_proto;

    logic                w_acc;
    logic                w_done;
    logic                w_early;
    logic                w_over;
    logic                w_capture;
    logic                w_mis;
    logic [CNT_W-1:0]    w_test_base;
    logic [CNT_W-1:0]    w_err_base;
    logic [CNT_W-1:0]    w_test_next;
    logic [CNT_W-1:0]    w_err_next;

    // r_full marks that the last slice is written and further beats are dropped
    assign s_ready   = (r_state == c_ST_LOAD);
    assign w_acc     = s_valid && s_ready;
    assign w_done    = w_acc && s_last;
    assign w_early   = w_done && !r_full && (r_bcnt != c_BCNT_MAX);
    assign w_over    = w_acc && r_full;
    assign w_capture = (r_state == c_ST_WAIT) && (r_settle == 8'd0);

`ifdef CLUSTER_DRV_MASK_EN
    logic [OUT_W-1:0] r_mask;
    assign w_mis = |((res_i ^ r_exp) & r_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_mask <= '0;
        else if (w_done) r_mask <= s_mask;
    end
`else
    assign w_mis = (res_i != r_exp);
`endif

    // A coincident clear restarts from zero but still counts this test
    assign w_test_base = clr ? '0 : r_test_cnt;
    assign w_err_base  = clr ? '0 : r_err_cnt;
    assign w_test_next = (w_capture && !(&w_test_base)) ? w_test_base + CNT_W'(1) : w_test_base;
    assign w_err_next  = (w_capture && w_mis && !(&w_err_base)) ? w_err_base + CNT_W'(1) : w_err_base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_LOAD;
            r_bcnt    <= '0;
            r_full    <= 1'b0;
            r_exp     <= '0;
            r_settle  <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_mis   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_LOAD: begin
                    if (w_done) begin
                        r_exp    <= s_exp;
                        r_bcnt   <= '0;
                        r_full   <= 1'b0;
                        r_settle <= c_SETTLE;
                        r_state  <= c_ST_WAIT;
                    end else if (w_acc && !r_full) begin
                        if (r_bcnt == c_BCNT_MAX) r_full <= 1'b1;
                        else                      r_bcnt <= r_bcnt + c_BCNT_W'(1);
                    end
                end
                c_ST_WAIT: begin
                    if (w_capture) begin
                        r_m_data  <= res_i;
                        r_m_mis   <= w_mis;
                        r_m_valid <= 1'b1;
                        r_state   <= c_ST_RESP;
                    end else begin
                        r_settle <= r_settle - 8'd1;
                    end
                end
                c_ST_RESP: begin
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        r_state   <= c_ST_LOAD;
                    end
                end
                default: r_state <= c_ST_LOAD;
            endcase
        end
    end

    // Early s_last zeroes every slice above the one being written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec <= '0;
        end else if (w_acc && !r_full) begin
            for (int k = 0; k < c_NBEATS - 1; k++) begin
                if (r_bcnt == c_BCNT_W'(k))
                    r_vec[k*WORD_W +: WORD_W] <= s_data;
                else if (w_early && (k > int'(r_bcnt)))
                    r_vec[k*WORD_W +: WORD_W] <= '0;
            end
            if (r_bcnt == c_BCNT_MAX)
                r_vec[c_LAST_LO +: c_LAST_W] <= s_data[c_LAST_W-1:0];
            else if (w_early)
                r_vec[c_LAST_LO +: c_LAST_W] <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_test_cnt <= '0;
            r_err_cnt  <= '0;
            r_proto    <= 1'b0;
        end else begin
            r_test_cnt <= w_test_next;
            r_err_cnt  <= w_err_next;
            if (w_early || w_over) r_proto <= 1'b1;
            else if (clr)          r_proto <= 1'b0;
        end
    end

    assign vec_o      = r_vec;
    assign m_valid    = r_m_valid;
    assign m_data     = r_m_data;
    assign m_mismatch = r_m_mis;
    assign test_cnt   = r_test_cnt;
    assign err_cnt    = r_err_cnt;
    assign proto_err  = r_proto;

endmodule
`default_nettype wire

// File: tb/tb_cluster_vector_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_cluster_vector_driver
// Function : Randomised scoreboard bench for cluster_vector_driver with a
//            bit-level reference model of vector assembly and result checking.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cluster_vector_driver;

    localparam int c_IN_W   = 1894;
    localparam int c_OUT_W  = 8;
    localparam int c_WORD_W = 32;
    localparam int c_SETTLE = 2;
    localparam int c_CNT_W  = 32;
    localparam int c_NBEATS = (c_IN_W + c_WORD_W - 1) / c_WORD_W;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic [c_WORD_W-1:0] s_data = '0;
    logic                s_last = 1'b0;
    logic [c_OUT_W-1:0]  s_exp = '0;
`ifdef CLUSTER_DRV_MASK_EN
    logic [c_OUT_W-1:0]  s_mask = '1;
`endif
    logic [c_IN_W-1:0]   vec_o;
    logic [c_OUT_W-1:0]  res_i;
    logic                m_valid;
    logic                m_ready = 1'b0;
    logic [c_OUT_W-1:0]  m_data;
    logic                m_mismatch;
    logic [c_CNT_W-1:0]  test_cnt;
    logic [c_CNT_W-1:0]  err_cnt;
    logic                proto_err;
    logic                clr = 1'b0;

    cluster_vector_driver #(
        .IN_W  (c_IN_W),
        .OUT_W (c_OUT_W),
        .WORD_W(c_WORD_W),
        .SETTLE(c_SETTLE),
        .CNT_W (c_CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_exp     (s_exp),
`ifdef CLUSTER_DRV_MASK_EN
        .s_mask    (s_mask),
`endif
        .vec_o     (vec_o),
        .res_i     (res_i),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_mismatch(m_mismatch),
        .test_cnt  (test_cnt),
        .err_cnt   (err_cnt),
        .proto_err (proto_err),
        .clr       (clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [c_OUT_W-1:0] data;
        logic               mis;
        logic [c_IN_W-1:0]  vec;
        logic [c_CNT_W-1:0] tcnt;
        logic [c_CNT_W-1:0] ecnt;
        logic               perr;
        int                 cyc;
    } exp_t;

    exp_t               sb_q[$];
    exp_t               mon_e;
    logic [c_IN_W-1:0]  mdl_vec = '0;
    logic [c_CNT_W-1:0] mdl_tcnt = '0;
    logic [c_CNT_W-1:0] mdl_ecnt = '0;
    logic               mdl_perr = 1'b0;
    logic [c_OUT_W-1:0] tweak = '0;
    int                 cyc = 0;
    int                 checks = 0;
    int                 passes = 0;
    bit                 hold_ready = 1'b0;
    bit                 ready_rand = 1'b0;

    // Stand-in cluster: XOR-fold of the input vector, perturbed by the bench
    function automatic logic [c_OUT_W-1:0] fold(input logic [c_IN_W-1:0] v);
        logic [c_OUT_W-1:0] r;
        r = '0;
        for (int i = 0; i < c_IN_W; i++) r[i % c_OUT_W] = r[i % c_OUT_W] ^ v[i];
        return r;
    endfunction

    function automatic logic [c_CNT_W-1:0] sat1(input logic [c_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1;
    endfunction

    always_comb res_i = fold(vec_o) ^ tweak;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    endtask

    task automatic chk_vec(input string name, input logic [c_IN_W-1:0] act, input logic [c_IN_W-1:0] req);
        int i;
        checks++;
        if (act === req) passes++;
        else begin
            i = 0;
            while (i < c_IN_W - 1 && act[i] === req[i]) i++;
            $display("FAIL %s: first differing bit %0d got %b expected %b", name, i, act[i], req[i]);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            m_ready = hold_ready ? 1'b0 : (ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    // Monitor: pops one expectation per result and checks handshake rules
    logic               pv = 1'b0;
    logic               pr = 1'b0;
    logic [c_OUT_W-1:0] pd = '0;
    logic               pm = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            pv = 1'b0;
            pr = 1'b0;
        end else begin
            if (pv && !pr) begin
                chk("m_valid_hold", m_valid, 1);
                chk("m_data_hold", m_data, pd);
                chk("m_mismatch_hold", m_mismatch, pm);
            end
            if (pv && pr) chk("s_ready_after_handshake", s_ready, 1);
            if (m_valid) chk("s_ready_in_resp", s_ready, 0);
            if (m_valid && !pv) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_result: got m_data 0x%0h expected no result", m_data);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("latency_cycle", cyc, mon_e.cyc);
                    chk("m_data", m_data, mon_e.data);
                    chk("m_mismatch", m_mismatch, mon_e.mis);
                    chk("test_cnt", test_cnt, mon_e.tcnt);
                    chk("err_cnt", err_cnt, mon_e.ecnt);
                    chk("proto_err", proto_err, mon_e.perr);
                    chk_vec("vec_o", vec_o, mon_e.vec);
                end
            end
            pv = m_valid;
            pr = m_ready;
            pd = m_data;
            pm = m_mismatch;
        end
    end

    task automatic send_vector(input int nb, input logic [c_OUT_W-1:0] exp, input logic [c_OUT_W-1:0] want,
                               input logic [c_OUT_W-1:0] mask, input bit idx_data, input bit clr_at_cap,
                               input bit abort);
        int                 guard;
        exp_t               e;
        logic [c_OUT_W-1:0] eff_mask;
        logic [c_CNT_W-1:0] tb_base;
        logic [c_CNT_W-1:0] eb_base;
        logic               bad;
        for (int k = 0; k < nb; k++) begin
            @(negedge clk);
            while (!idx_data && $urandom_range(0, 4) == 0) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
            s_valid = 1'b1;
            s_data  = idx_data ? c_WORD_W'(k) : $urandom;
            s_last  = (k == nb - 1);
            s_exp   = exp;
`ifdef CLUSTER_DRV_MASK_EN
            s_mask  = mask;
`endif
            guard = 0;
            while (!s_ready && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (!s_ready) begin
                checks++;
                $display("FAIL s_ready_timeout: got s_ready 0 expected 1 within 200 cycles");
                s_valid = 1'b0;
                s_last  = 1'b0;
                return;
            end
            @(posedge clk);
            if (k < c_NBEATS) begin
                for (int b = 0; b < c_WORD_W; b++)
                    if (k * c_WORD_W + b < c_IN_W) mdl_vec[k*c_WORD_W + b] = s_data[b];
            end else begin
                mdl_perr = 1'b1;
            end
            if (k == nb - 1 && k < c_NBEATS - 1) begin
                for (int b = (k + 1) * c_WORD_W; b < c_IN_W; b++) mdl_vec[b] = 1'b0;
                mdl_perr = 1'b1;
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = $urandom;
        s_exp   = $urandom;
        tweak   = want ^ fold(mdl_vec);
`ifdef CLUSTER_DRV_MASK_EN
        eff_mask = mask;
`else
        eff_mask = '1;
`endif
        if (abort) begin
            rst_n = 1'b0;
            #1;
            chk("abort_m_valid", m_valid, 0);
            chk("abort_s_ready", s_ready, 1);
            chk("abort_vec_zero", |vec_o, 0);
            chk("abort_cnt_zero", {test_cnt, err_cnt}, 0);
            chk("abort_m_data", {proto_err, m_mismatch, m_data}, 0);
            mdl_vec  = '0;
            mdl_tcnt = '0;
            mdl_ecnt = '0;
            mdl_perr = 1'b0;
            sb_q.delete();
            @(negedge clk);
            rst_n = 1'b1;
            bad = 1'b0;
            repeat (6) begin
                @(negedge clk);
                if (m_valid || !s_ready) bad = 1'b1;
            end
            chk("no_result_after_abort", bad, 0);
            return;
        end
        e.data = want;
        e.mis  = |((want ^ exp) & eff_mask);
        e.vec  = mdl_vec;
        tb_base = clr_at_cap ? '0 : mdl_tcnt;
        eb_base = clr_at_cap ? '0 : mdl_ecnt;
        if (clr_at_cap) mdl_perr = 1'b0;
        mdl_tcnt = sat1(tb_base);
        mdl_ecnt = e.mis ? sat1(eb_base) : eb_base;
        e.tcnt = mdl_tcnt;
        e.ecnt = mdl_ecnt;
        e.perr = mdl_perr;
        e.cyc  = cyc + c_SETTLE + 1;
        sb_q.push_back(e);
        if (clr_at_cap) begin
            repeat (c_SETTLE) @(negedge clk);
            clr = 1'b1;
            @(negedge clk);
            clr = 1'b0;
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb_q.size() != 0 && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            $display("FAIL drain: got %0d results outstanding expected 0", sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic clear_counters();
        drain();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        mdl_tcnt = '0;
        mdl_ecnt = '0;
        mdl_perr = 1'b0;
        chk("clr_test_cnt", test_cnt, 0);
        chk("clr_err_cnt", err_cnt, 0);
        chk("clr_proto_err", proto_err, 0);
    endtask

    initial begin
        int                 nb;
        logic [c_OUT_W-1:0] ex;
        logic [c_OUT_W-1:0] want;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_s_ready", s_ready, 1);
        chk("reset_m_valid", m_valid, 0);
        chk("reset_outputs", {proto_err, m_mismatch, m_data}, 0);
        chk("reset_counters", {test_cnt, err_cnt}, 0);
        chk("reset_vec", |vec_o, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("s_ready_after_reset", s_ready, 1);

        send_vector(c_NBEATS, 8'hA5, 8'hA5, 8'hFF, 1'b1, 1'b0, 1'b0);
        drain();
        chk("vec_low_word", vec_o[31:0], 0);
        chk("vec_top_bits", vec_o[c_IN_W-1:c_IN_W-6], 59);

        hold_ready = 1'b1;
        send_vector(c_NBEATS, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0);
        repeat (c_SETTLE + 12) @(negedge clk);
        chk("m_valid_backpressure", m_valid, 1);
        chk("m_data_backpressure", m_data, 8'h01);
        hold_ready = 1'b0;
        drain();

        send_vector(5, 8'h3C, 8'h3C, 8'hFF, 1'b0, 1'b0, 1'b0);
        drain();
        chk("early_upper_zero", |vec_o[c_IN_W-1:160], 0);
        chk("early_proto_err", proto_err, 1);
        clear_counters();

        send_vector(c_NBEATS + 2, 8'h11, 8'h11, 8'hFF, 1'b0, 1'b0, 1'b0);
        drain();
        chk("overlong_proto_err", proto_err, 1);
        chk("overlong_test_cnt", test_cnt, 1);

        force dut.r_test_cnt = '1;
        force dut.r_err_cnt  = '1;
        @(negedge clk);
        release dut.r_test_cnt;
        release dut.r_err_cnt;
        mdl_tcnt = '1;
        mdl_ecnt = '1;
        send_vector(c_NBEATS, 8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0, 1'b0);
        drain();
        send_vector(c_NBEATS, 8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b1, 1'b0);
        drain();
        chk("coincident_clr_test_cnt", test_cnt, 1);
        chk("coincident_clr_err_cnt", err_cnt, 1);

        send_vector(c_NBEATS, 8'h55, 8'h55, 8'hFF, 1'b0, 1'b0, 1'b1);
        send_vector(c_NBEATS, 8'h55, 8'h55, 8'hFF, 1'b1, 1'b0, 1'b0);
        drain();

`ifdef CLUSTER_DRV_MASK_EN
        send_vector(c_NBEATS, 8'hA5, 8'hA5 ^ 8'hF0, 8'h0F, 1'b0, 1'b0, 1'b0);
        drain();
`endif

        ready_rand = 1'b1;
        for (int t = 0; t < 25; t++) begin
            case ($urandom_range(0, 9))
                0:       nb = $urandom_range(1, c_NBEATS - 1);
                1:       nb = $urandom_range(c_NBEATS + 1, c_NBEATS + 3);
                default: nb = c_NBEATS;
            endcase
            ex   = $urandom;
            want = ($urandom_range(0, 1) == 0) ? ex : 8'($urandom);
            send_vector(nb, ex, want, 8'($urandom), 1'b0, 1'b0, 1'b0);
        end
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
